// File: rtl/tlu_emulator_pkg.sv
// tlu_emulator_pkg: FSM state encoding and register map shared by the TLU emulator
package tlu_emulator_pkg;
    typedef enum logic [1:0] {IDLE, TRIG, SHIFT, RELEASE} tlu_state_t;
    localparam logic [15:0] ADDR_VERSION     = 16'd0;
    localparam logic [15:0] ADDR_CONF        = 16'd1;
    localparam logic [15:0] ADDR_PERIOD_LO   = 16'd2;
    localparam logic [15:0] ADDR_PERIOD_HI   = 16'd3;
    localparam logic [15:0] ADDR_TIMEOUT_LO  = 16'd4;
    localparam logic [15:0] ADDR_TIMEOUT_HI  = 16'd5;
    localparam logic [15:0] ADDR_TRIG_NUM_LO = 16'd6;
    localparam logic [15:0] ADDR_TRIG_NUM_HI = 16'd7;
    localparam logic [15:0] ADDR_STATUS      = 16'd8;
endpackage

// File: rtl/tlu_emulator_sync_edge_detect.sv
// sync_edge_detect: 2-FF synchroniser with edge pulses derived from the synchronised level
module sync_edge_detect (
    input  logic BUS_CLK,
    input  logic BUS_RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta, sync, prev;
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) {meta, sync, prev} <= 3'b000;
        else {meta, sync, prev} <= {din, meta, sync};
    end
    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;
endmodule

// File: rtl/tlu_emulator.sv
// tlu_emulator: TLU-side trigger handshake emulator on an 8-bit register bus
module tlu_emulator
    import tlu_emulator_pkg::*;
#(
    parameter int         TRIG_NUM_BITS = 15,
    parameter logic [7:0] VERSION       = 8'd1
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic [15:0]              BUS_ADD,
    input  logic [7:0]               BUS_DATA_IN,
    input  logic                     BUS_RD,
    input  logic                     BUS_WR,
    output logic [7:0]               BUS_DATA_OUT,
    input  logic                     TLU_CLOCK,
    input  logic                     TLU_BUSY,
    output logic                     TLU_TRIGGER,
    output logic [TRIG_NUM_BITS-1:0] TRIGGER_COUNT,
    output logic                     TIMEOUT_ERR
);
    tlu_state_t state;
    logic busy_sync, busy_rise, busy_fall, clk_level, clk_rise, clk_fall, unused_sync;
    logic enable, mode, single_pending, last_bit, wr_soft, start, timed_out;
    logic [15:0] period, timeout, since_start, state_cnt, preset, count16;
    logic [7:0] trig_lo, rd_data;
    logic [TRIG_NUM_BITS-1:0] num;
    logic [3:0] k;

    sync_edge_detect i_sync_clk (.BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .din(TLU_CLOCK),
                                 .level(clk_level), .rise(clk_rise), .fall(clk_fall));
    sync_edge_detect i_sync_busy (.BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .din(TLU_BUSY),
                                  .level(busy_sync), .rise(busy_rise), .fall(busy_fall));
    assign unused_sync = &{clk_level, busy_rise, busy_fall};

    assign wr_soft   = BUS_WR && BUS_ADD == ADDR_VERSION;
    assign start     = state == IDLE && (single_pending || (enable && since_start >= period));
    assign timed_out = state != IDLE && timeout != 16'd0 && state_cnt >= timeout - 16'd1;
    assign preset    = {BUS_DATA_IN, trig_lo};
    assign count16   = 16'(TRIGGER_COUNT);
    assign rd_data   = BUS_ADD == ADDR_VERSION     ? VERSION :
                       BUS_ADD == ADDR_CONF        ? {5'd0, single_pending, mode, enable} :
                       BUS_ADD == ADDR_PERIOD_LO   ? period[7:0] :
                       BUS_ADD == ADDR_PERIOD_HI   ? period[15:8] :
                       BUS_ADD == ADDR_TIMEOUT_LO  ? timeout[7:0] :
                       BUS_ADD == ADDR_TIMEOUT_HI  ? timeout[15:8] :
                       BUS_ADD == ADDR_TRIG_NUM_LO ? count16[7:0] :
                       BUS_ADD == ADDR_TRIG_NUM_HI ? count16[15:8] :
                       BUS_ADD == ADDR_STATUS      ? {4'd0, single_pending, TIMEOUT_ERR, state != IDLE, busy_sync} :
                                                     8'd0;

    // Configuration survives a soft reset; only the hard reset clears it.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            {mode, enable} <= 2'b00;
            period         <= 16'd0;
            timeout        <= 16'd0;
        end else if (BUS_WR) begin
            if (BUS_ADD == ADDR_CONF)       {mode, enable} <= BUS_DATA_IN[1:0];
            if (BUS_ADD == ADDR_PERIOD_LO)  period[7:0]    <= BUS_DATA_IN;
            if (BUS_ADD == ADDR_PERIOD_HI)  period[15:8]   <= BUS_DATA_IN;
            if (BUS_ADD == ADDR_TIMEOUT_LO) timeout[7:0]   <= BUS_DATA_IN;
            if (BUS_ADD == ADDR_TIMEOUT_HI) timeout[15:8]  <= BUS_DATA_IN;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || wr_soft) BUS_DATA_OUT <= 8'd0;
        else if (BUS_RD) BUS_DATA_OUT <= rd_data;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || wr_soft) begin
            state          <= IDLE;
            TLU_TRIGGER    <= 1'b0;
            TRIGGER_COUNT  <= '0;
            TIMEOUT_ERR    <= 1'b0;
            single_pending <= 1'b0;
            since_start    <= 16'd0;
            state_cnt      <= 16'd0;
            trig_lo        <= 8'd0;
            num            <= '0;
            k              <= 4'd0;
            last_bit       <= 1'b0;
        end else begin
            // Cleared to 1 so that a start lands exactly PERIOD cycles after the previous one.
            since_start <= start ? 16'd1 : since_start + 16'(since_start != 16'hFFFF);
            state_cnt   <= state_cnt + 16'd1;
            if (BUS_WR && BUS_ADD == ADDR_TRIG_NUM_LO) trig_lo <= BUS_DATA_IN;
            if (BUS_WR && BUS_ADD == ADDR_CONF && BUS_DATA_IN[2] && !single_pending) single_pending <= 1'b1;
            else if (start) single_pending <= 1'b0;
            if (timed_out) begin
                state       <= IDLE;
                TLU_TRIGGER <= 1'b0;
                TIMEOUT_ERR <= 1'b1;
                state_cnt   <= 16'd0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state         <= TRIG;
                        TLU_TRIGGER   <= 1'b1;
                        num           <= TRIGGER_COUNT;
                        TRIGGER_COUNT <= TRIGGER_COUNT + TRIG_NUM_BITS'(1);
                        state_cnt     <= 16'd0;
                    end
                    TRIG: if (busy_sync) begin
                        state       <= mode ? SHIFT : RELEASE;
                        TLU_TRIGGER <= 1'b0;
                        k           <= 4'd0;
                        last_bit    <= 1'b0;
                        state_cnt   <= 16'd0;
                    end
                    SHIFT: if (last_bit && clk_fall) begin
                        state       <= RELEASE;
                        TLU_TRIGGER <= 1'b0;
                        state_cnt   <= 16'd0;
                    end else if (!last_bit && clk_rise) begin
                        TLU_TRIGGER <= num[k];
                        k           <= k + 4'd1;
                        last_bit    <= k == 4'(TRIG_NUM_BITS - 1);
                    end
                    RELEASE: if (!busy_sync) begin
                        state     <= IDLE;
                        state_cnt <= 16'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (BUS_WR && BUS_ADD == ADDR_TRIG_NUM_HI) TRIGGER_COUNT <= preset[TRIG_NUM_BITS-1:0];
        end
    end
endmodule

// File: tb/tb_tlu_emulator.sv
// tb_tlu_emulator: scoreboard bench with a reactive DUT-side handshake model
module tb_tlu_emulator;
    logic        BUS_CLK = 1'b0, BUS_RST = 1'b1, BUS_RD = 1'b0, BUS_WR = 1'b0;
    logic [15:0] BUS_ADD = 16'd0;
    logic [7:0]  BUS_DATA_IN = 8'd0, BUS_DATA_OUT;
    logic        TLU_CLOCK = 1'b0, TLU_BUSY = 1'b0, TLU_TRIGGER, TIMEOUT_ERR;
    logic [14:0] TRIGGER_COUNT;

    tlu_emulator #(.TRIG_NUM_BITS(15), .VERSION(8'd1)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(BUS_DATA_OUT), .TLU_CLOCK(TLU_CLOCK),
        .TLU_BUSY(TLU_BUSY), .TLU_TRIGGER(TLU_TRIGGER), .TRIGGER_COUNT(TRIGGER_COUNT),
        .TIMEOUT_ERR(TIMEOUT_ERR));

    always #5 BUS_CLK = ~BUS_CLK;
    int cyc = 0;
    always @(posedge BUS_CLK) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {string name; logic [7:0] val;} rd_exp_t;
    rd_exp_t rd_q[$];
    int exp_num_q[$];
    logic rd_d = 1'b0;
    always @(posedge BUS_CLK) rd_d <= BUS_RD;
    always @(negedge BUS_CLK) begin
        rd_exp_t e;
        if (rd_d) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h, required no read data", BUS_DATA_OUT);
            end else begin
                e = rd_q.pop_front();
                check(e.name, int'(BUS_DATA_OUT), int'(e.val));
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge BUS_CLK); BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
        @(negedge BUS_CLK); BUS_WR = 1'b0;
    endtask
    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string name);
        @(negedge BUS_CLK); BUS_ADD = a; BUS_RD = 1'b1; rd_q.push_back('{name, e});
        @(negedge BUS_CLK); BUS_RD = 1'b0;
    endtask

    // DUT-side model: 0 never busy, 1 simple busy pulse, 2 data mode with DIVISOR 12
    int model_mode = 1, busy_delay = 5, busy_hold = 20, abort_bit = -1;
    int starts = 0, busy_cyc = 0, fall_cyc = 0, start_cyc[$];
    logic model_busy = 1'b0, at_abort = 1'b0;

    task automatic wait_trig_low();
        int t = 0;
        while (TLU_TRIGGER && t < 200) begin @(negedge BUS_CLK); t++; end
        check("trigger_release", int'(TLU_TRIGGER), 0);
    endtask

    task automatic handshake();
        int exp = -1, dec = 0, t;
        starts++;
        start_cyc.push_back(cyc);
        if (exp_num_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_trigger: got count 0x%0h, required no trigger", TRIGGER_COUNT);
        end else begin
            exp = exp_num_q.pop_front();
            check("issued_num", (int'(TRIGGER_COUNT) - 1) & 32'h7FFF, exp);
        end
        if (model_mode == 0) begin
            wait_trig_low();
            fall_cyc = cyc;
            return;
        end
        repeat (busy_delay) @(negedge BUS_CLK);
        TLU_BUSY = 1'b1;
        busy_cyc = cyc;
        wait_trig_low();
        fall_cyc = cyc;
        if (model_mode == 1) begin
            while (cyc - busy_cyc < busy_hold) @(negedge BUS_CLK);
            TLU_BUSY = 1'b0;
            return;
        end
        repeat (2) @(negedge BUS_CLK);
        for (int i = 0; i < 15; i++) begin
            TLU_CLOCK = 1'b1;
            repeat (6) @(negedge BUS_CLK);
            if (i == abort_bit) begin
                at_abort = 1'b1;
                t = 0;
                while (at_abort && t < 200) begin @(negedge BUS_CLK); t++; end
                TLU_CLOCK = 1'b0;
                TLU_BUSY = 1'b0;
                return;
            end
            dec |= int'(TLU_TRIGGER) << i;
            TLU_CLOCK = 1'b0;
            repeat (6) @(negedge BUS_CLK);
        end
        TLU_BUSY = 1'b0;
        check("decoded_num", dec, exp);
    endtask

    initial begin : model
        logic prev = 1'b0;
        forever begin
            @(negedge BUS_CLK);
            if (TLU_TRIGGER === 1'b1 && !prev) begin
                model_busy = 1'b1;
                handshake();
                model_busy = 1'b0;
            end
            prev = TLU_TRIGGER;
        end
    end

    task automatic wait_done(input int n);
        int t = 0;
        while ((starts < n || model_busy) && t < 3000) begin @(negedge BUS_CLK); t++; end
        check("handshake_done", int'(starts >= n && !model_busy), 1);
        repeat (8) @(negedge BUS_CLK);
    endtask

    initial begin
        int base, t;
        repeat (3) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        check("rst_trigger", int'(TLU_TRIGGER), 0);
        check("rst_count", int'(TRIGGER_COUNT), 0);
        check("rst_timeout_err", int'(TIMEOUT_ERR), 0);
        check("rst_data_out", int'(BUS_DATA_OUT), 0);
        bus_read(16'd0, 8'h01, "version");
        bus_read(16'd8, 8'h00, "rst_status");

        // 1: simple mode single trigger
        exp_num_q.push_back(0);
        bus_write(16'd1, 8'h04);
        wait_done(1);
        check("t1_starts", starts, 1);
        check("t1_busy_to_fall", fall_cyc - busy_cyc, 3);
        check("t1_pulse_len", fall_cyc - start_cyc[0], 8);
        check("t1_count", int'(TRIGGER_COUNT), 1);
        bus_read(16'd8, 8'h00, "t1_status");
        bus_read(16'd6, 8'h01, "t1_num_lo");

        // 2: data mode, preset 0x1234
        model_mode = 2;
        bus_write(16'd6, 8'h34);
        bus_write(16'd7, 8'h12);
        exp_num_q.push_back(32'h1234);
        bus_write(16'd1, 8'h06);
        wait_done(2);
        check("t2_count", int'(TRIGGER_COUNT), 32'h1235);
        bus_read(16'd6, 8'h35, "t2_num_lo");
        bus_read(16'd7, 8'h12, "t2_num_hi");

        // 3: periodic triggers every 100 cycles
        model_mode = 1; busy_delay = 1; busy_hold = 6;
        bus_write(16'd1, 8'h00);
        bus_write(16'd2, 8'd100);
        bus_write(16'd3, 8'd0);
        bus_write(16'd0, 8'd0);
        base = starts;
        start_cyc.delete();
        for (int i = 0; i < 10; i++) exp_num_q.push_back(i);
        bus_write(16'd1, 8'h01);
        t = 0;
        while (starts == base && t < 300) begin @(negedge BUS_CLK); t++; end
        repeat (950) @(negedge BUS_CLK);
        bus_write(16'd1, 8'h00);
        repeat (20) @(negedge BUS_CLK);
        check("t3_starts", starts - base, 10);
        for (int i = 1; i < start_cyc.size(); i++) check($sformatf("t3_spacing%0d", i), start_cyc[i] - start_cyc[i-1], 100);
        check("t3_all_sent", exp_num_q.size(), 0);

        // 4: timeout with no BUSY, then a normal single
        model_mode = 0; busy_delay = 5; busy_hold = 20;
        bus_write(16'd0, 8'd0);
        bus_write(16'd4, 8'd50);
        bus_write(16'd5, 8'd0);
        base = starts;
        exp_num_q.push_back(0);
        bus_write(16'd1, 8'h04);
        wait_done(base + 1);
        check("t4_timeout_len", fall_cyc - start_cyc[start_cyc.size()-1], 50);
        check("t4_timeout_err", int'(TIMEOUT_ERR), 1);
        bus_read(16'd8, 8'h04, "t4_status");
        bus_read(16'd6, 8'h01, "t4_num_lo");
        model_mode = 1;
        exp_num_q.push_back(1);
        bus_write(16'd1, 8'h04);
        wait_done(base + 2);
        bus_read(16'd8, 8'h04, "t4_status_sticky");
        bus_read(16'd6, 8'h02, "t4_num_lo2");

        // 5: soft reset in the middle of the shift, at bit 7
        model_mode = 2; abort_bit = 7;
        bus_write(16'd4, 8'd0);
        bus_write(16'd6, 8'h80);
        bus_write(16'd7, 8'h00);
        base = starts;
        exp_num_q.push_back(32'h80);
        bus_write(16'd1, 8'h06);
        t = 0;
        while (!at_abort && t < 1000) begin @(negedge BUS_CLK); t++; end
        check("t5_reached_bit7", int'(at_abort), 1);
        check("t5_bit7_value", int'(TLU_TRIGGER), 1);
        bus_write(16'd0, 8'd0);
        check("t5_trigger_after_reset", int'(TLU_TRIGGER), 0);
        at_abort = 1'b0;
        abort_bit = -1;
        wait_done(base + 1);
        bus_read(16'd8, 8'h00, "t5_status");
        bus_read(16'd6, 8'h00, "t5_num_lo");
        bus_read(16'd7, 8'h00, "t5_num_hi");
        bus_read(16'd1, 8'h02, "t5_conf");

        // 6: count wrap at 0x7FFF
        bus_write(16'd6, 8'hFF);
        bus_write(16'd7, 8'h7F);
        base = starts;
        exp_num_q.push_back(32'h7FFF);
        bus_write(16'd1, 8'h06);
        wait_done(base + 1);
        check("t6_count_wrap", int'(TRIGGER_COUNT), 0);
        bus_read(16'd6, 8'h00, "t6_num_lo");
        bus_read(16'd7, 8'h00, "t6_num_hi");

        repeat (4) @(negedge BUS_CLK);
        check("reads_drained", rd_q.size(), 0);
        check("nums_drained", exp_num_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
